microwave_sequencer: RTL and testbench

- Cooking-cycle controller for the microwave front panel: the block `maindebbug` is built around.
- Latches time (BCD m:ss) and power level on confirm, counts down once per second and enforces the door interlock.
- Drives light, turntable motor, duty-cycled heater and end-of-cycle buzzer.
- Exposes a 4-digit BCD display and a 4-bit state code for debug.

---
 rtl/microwave_sequencer_pkg.sv | 22 ++
 rtl/microwave_sequencer_if.sv | 29 ++
 rtl/microwave_sequencer_bcd_mmss_down.sv | 61 ++++++
 rtl/microwave_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_microwave_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_sequencer_pkg.sv
// Shared encodings and BCD helpers for the microwave cooking-cycle controller.
package microwave_sequencer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MAX_TENS  = 4'd5;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_COOK  = 4'd2;
    localparam state_t ST_PAUSE = 4'd3;
    localparam state_t ST_DONE  = 4'd4;

    // m:ss where every digit is decimal and the seconds-tens digit stays below 6
    function automatic logic bcd_time_valid(input logic [3*BCD_W-1:0] t);
        return (t[2*BCD_W +: BCD_W] <= BCD_MAX_UNITS) &&
               (t[BCD_W   +: BCD_W] <= BCD_MAX_TENS)  &&
               (t[0       +: BCD_W] <= BCD_MAX_UNITS);
    endfunction

endpackage

// File: rtl/microwave_sequencer_if.sv
// Front-panel bundle: time/power/door/confirm inputs, display and actuator outputs.
interface microwave_sequencer_if;
    import microwave_sequencer_pkg::*;

    logic [3*BCD_W-1:0] t;
    logic               conf;
    logic [BCD_W-1:0]   r;
    logic               porta;
    logic [BCD_W-1:0]   led1;
    logic [BCD_W-1:0]   led2;
    logic [BCD_W-1:0]   led3;
    logic [BCD_W-1:0]   led4;
    logic               luz;
    logic               motor;
    logic               aquec;
    logic               som;
    state_t             est;

    modport master (
        output t, conf, r, porta,
        input  led1, led2, led3, led4, luz, motor, aquec, som, est
    );

    modport slave (
        input  t, conf, r, porta,
        output led1, led2, led3, led4, luz, motor, aquec, som, est
    );

endinterface

// File: rtl/microwave_sequencer_bcd_mmss_down.sv
// Loadable m:ss BCD down-counter; holds at 0:00 instead of wrapping.
module microwave_sequencer_bcd_mmss_down
    import microwave_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [3*BCD_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic [BCD_W-1:0]   min_o,
    output logic [BCD_W-1:0]   tens_o,
    output logic [BCD_W-1:0]   units_o,
    output logic               zero_o
);

    logic [BCD_W-1:0] min_q, min_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] units_q, units_d;
    logic             zero;

    assign zero = (min_q == '0) && (tens_q == '0) && (units_q == '0);

    always_comb begin
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        if (load_i) begin
            {min_d, tens_d, units_d} = load_val_i;
        end else if (dec_i && !zero) begin
            if (units_q != '0) begin
                units_d = units_q - BCD_W'(1);
            end else begin
                units_d = BCD_MAX_UNITS;
                if (tens_q != '0) begin
                    tens_d = tens_q - BCD_W'(1);
                end else begin
                    tens_d = BCD_MAX_TENS;
                    min_d  = min_q - BCD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q   <= '0;
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            min_q   <= min_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign min_o   = min_q;
    assign tens_o  = tens_q;
    assign units_o = units_q;
    assign zero_o  = zero;

endmodule

// File: rtl/microwave_sequencer.sv
// Cooking-cycle controller: latches m:ss and power, counts down per second,
// enforces the door interlock and drives light, turntable, heater and buzzer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | display tracks t/r, waiting for a valid confirm
//   ST_COOK  | counting down, motor and light on, heater duty-cycled
//   ST_PAUSE | door open or stopped; count, prescaler and window held
//   ST_DONE  | buzzer sounds for BEEP_SECS, then back to idle
module microwave_sequencer
    import microwave_sequencer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int BEEP_SECS     = 3,
    parameter int DUTY_WINDOW   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    microwave_sequencer_if.slave mw
);

    localparam int PRESC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BEEP_CYC = BEEP_SECS * TICKS_PER_SEC;
    localparam int BEEP_W   = (BEEP_CYC > 1) ? $clog2(BEEP_CYC + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [BEEP_W-1:0]  BEEP_LOAD  = BEEP_W'(BEEP_CYC - 1);
    localparam logic [3:0]         WIN_LAST   = 4'(DUTY_WINDOW - 1);
    localparam logic [BCD_W-1:0]   R_CONT     = 4'd10;

    logic conf_s1_q, conf_s2_q, conf_s3_q;
    logic door_s1_q, door_s2_q;

    state_t state_q, state_d;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         win_q, win_d;
    logic [BEEP_W-1:0]  beep_q, beep_d;
    logic [BCD_W-1:0]   rlat_q, rlat_d;

    logic luz_q, luz_d;
    logic motor_q, motor_d;
    logic aquec_q, aquec_d;
    logic som_q, som_d;

    logic [BCD_W-1:0] cnt_min, cnt_tens, cnt_units;
    logic             cnt_zero;

    logic conf_rise, door, t_ok, t_zero;
    logic cnt_last, wrap, final_tick, advance, sec_tick, cnt_load;

    assign conf_rise = conf_s2_q & ~conf_s3_q;
    assign door      = door_s2_q;
    assign t_zero    = (mw.t == '0);
    assign t_ok      = bcd_time_valid(mw.t) && !t_zero;

    assign cnt_last   = (cnt_min == '0) && (cnt_tens == '0) && (cnt_units == BCD_W'(1));
    assign wrap       = (presc_q == PRESC_LAST);
    // The last second completes even if the door opened on the same edge.
    assign final_tick = (state_q == ST_COOK) && wrap && cnt_last;
    assign advance    = (state_q == ST_COOK) && (!door || final_tick);
    assign sec_tick   = advance && wrap;

    // In idle the count register mirrors t, which doubles as the load on start
    // and as the clear on cancel (t is zero then).
    assign cnt_load = (state_q == ST_IDLE) || (state_d == ST_IDLE);

    microwave_sequencer_bcd_mmss_down u_count (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (mw.t),
        .dec_i      (sec_tick),
        .min_o      (cnt_min),
        .tens_o     (cnt_tens),
        .units_o    (cnt_units),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_s1_q <= 1'b0;
            conf_s2_q <= 1'b0;
            conf_s3_q <= 1'b0;
            door_s1_q <= 1'b0;
            door_s2_q <= 1'b0;
        end else begin
            conf_s1_q <= mw.conf;
            conf_s2_q <= conf_s1_q;
            conf_s3_q <= conf_s2_q;
            door_s1_q <= mw.porta;
            door_s2_q <= door_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            luz_q   <= 1'b0;
            motor_q <= 1'b0;
            aquec_q <= 1'b0;
            som_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            luz_q   <= luz_d;
            motor_q <= motor_d;
            aquec_q <= aquec_d;
            som_q   <= som_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (conf_rise && t_ok) begin
                    state_d = door ? ST_PAUSE : ST_COOK;
                end
            end
            ST_COOK: begin
                if (final_tick || cnt_zero) begin
                    state_d = ST_DONE;
                end else if (door) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (conf_rise) begin
                    if (t_zero) begin
                        state_d = ST_IDLE;
                    end else if (!door) begin
                        state_d = ST_COOK;
                    end
                end
            end
            ST_DONE: begin
                if (door || (beep_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        win_d   = win_q;
        beep_d  = '0;
        rlat_d  = cnt_load ? mw.r : rlat_q;

        if (state_q == ST_IDLE) begin
            presc_d = '0;
            win_d   = '0;
        end else begin
            if (advance) begin
                presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
            end
            if (sec_tick) begin
                win_d = (win_q == WIN_LAST) ? 4'd0 : win_q + 4'd1;
            end
        end

        if (state_d == ST_DONE) begin
            beep_d = (state_q == ST_DONE) ? beep_q - BEEP_W'(1) : BEEP_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            win_q   <= '0;
            beep_q  <= '0;
            rlat_q  <= '0;
        end else begin
            presc_q <= presc_d;
            win_q   <= win_d;
            beep_q  <= beep_d;
            rlat_q  <= rlat_d;
        end
    end

    // Outputs are decoded from next-state values so they line up with est.
    always_comb begin
        luz_d   = (state_d == ST_COOK) || door || (state_d == ST_DONE);
        motor_d = (state_d == ST_COOK);
        aquec_d = (state_d == ST_COOK) && ((rlat_d >= R_CONT) || (win_d < rlat_d));
        som_d   = (state_d == ST_DONE);
    end

    assign mw.est   = state_q;
    assign mw.led1  = cnt_min;
    assign mw.led2  = cnt_tens;
    assign mw.led3  = cnt_units;
    assign mw.led4  = rlat_q;
    assign mw.luz   = luz_q;
    assign mw.motor = motor_q;
    assign mw.aquec = aquec_q;
    assign mw.som   = som_q;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Self-checking bench for microwave_sequencer at four ticks per second.
module tb_microwave_sequencer;
    import microwave_sequencer_pkg::*;

    localparam int TPS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    microwave_sequencer_if mw ();

    microwave_sequencer #(
        .TICKS_PER_SEC (TPS),
        .BEEP_SECS     (3),
        .DUTY_WINDOW   (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mw    (mw)
    );

    typedef struct {
        string       name;
        logic [23:0] exp;
    } sb_t;

    typedef struct {
        logic [11:0] t;
        logic [3:0]  r;
        logic        porta;
    } vec_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic logic [23:0] pack(input logic [3:0] est, input logic [3:0] l1,
                                         input logic [3:0] l2, input logic [3:0] l3,
                                         input logic [3:0] l4, input logic luz,
                                         input logic motor, input logic aquec,
                                         input logic som);
        return {est, l1, l2, l3, l4, luz, motor, aquec, som};
    endfunction

    function automatic logic [23:0] dut_snap();
        return pack(mw.est, mw.led1, mw.led2, mw.led3, mw.led4,
                    mw.luz, mw.motor, mw.aquec, mw.som);
    endfunction

    task automatic push_exp(input string name, input logic [23:0] e);
        sb_t s;
        s.name = name;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check_sb();
        sb_t         s;
        logic [23:0] act;
        while (sb_q.size() > 0) begin
            s   = sb_q.pop_front();
            act = dut_snap();
            n_checks++;
            if (act === s.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: actual %h required %h (est,led1,led2,led3,led4,luz/motor/aquec/som)",
                         s.name, act, s.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic conf_pulse();
        mw.conf = 1'b1;
        tick(3);
        mw.conf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];

        // 1: reset with random inputs, then release into idle
        rst_n    = 1'b0;
        mw.t     = 12'($urandom);
        mw.r     = 4'($urandom);
        mw.conf  = 1'($urandom);
        mw.porta = 1'($urandom);
        push_exp("reset_outputs", 24'h0);
        tick(3);
        check_sb();
        mw.t = 12'h000; mw.r = 4'd0; mw.conf = 1'b0; mw.porta = 1'b0;
        #2 rst_n = 1'b1;
        push_exp("idle_after_release", pack(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0));
        tick(3);
        check_sb();

        // 2: full cycle 0:12 at power 5
        mw.t = 12'h012; mw.r = 4'd5;
        tick(2);
        push_exp("cook_start", pack(4'd2, 4'd0, 4'd1, 4'd2, 4'd5, 1, 1, 1, 0));
        conf_pulse();
        check_sb();
        for (int s = 1; s <= 11; s++) begin
            push_exp($sformatf("cook_sec%0d", s),
                     pack(4'd2, 4'd0, 4'((12 - s) / 10), 4'((12 - s) % 10), 4'd5,
                          1, 1, ((s % 10) < 5), 0));
            tick(TPS);
            check_sb();
        end
        push_exp("done_entry", pack(4'd4, 4'd0, 4'd0, 4'd0, 4'd5, 1, 0, 0, 1));
        tick(TPS);
        check_sb();
        push_exp("done_last_beep", pack(4'd4, 4'd0, 4'd0, 4'd0, 4'd5, 1, 0, 0, 1));
        tick(11);
        check_sb();
        push_exp("done_to_idle", pack(4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 0, 0, 0, 0));
        tick(1);
        check_sb();

        // 3: 1:00 borrows across both digits, then pause and cancel
        mw.t = 12'h100; mw.r = 4'd0;
        tick(2);
        push_exp("borrow_start", pack(4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0));
        conf_pulse();
        check_sb();
        push_exp("borrow_059", pack(4'd2, 4'd0, 4'd5, 4'd9, 4'd0, 1, 1, 0, 0));
        tick(TPS);
        check_sb();
        mw.porta = 1'b1;
        push_exp("borrow_pause", pack(4'd3, 4'd0, 4'd5, 4'd9, 4'd0, 1, 0, 0, 0));
        tick(3);
        check_sb();
        mw.t = 12'h000;
        push_exp("borrow_cancel", pack(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0));
        conf_pulse();
        check_sb();
        mw.porta = 1'b0;
        tick(3);

        // 4: door interlock, resume, pause again, cancel
        mw.t = 12'h012; mw.r = 4'd5;
        tick(2);
        conf_pulse();
        tick(18);
        mw.porta = 1'b1;
        push_exp("door_pause_007", pack(4'd3, 4'd0, 4'd0, 4'd7, 4'd5, 1, 0, 0, 0));
        tick(3);
        check_sb();
        mw.porta = 1'b0;
        push_exp("resume_007", pack(4'd2, 4'd0, 4'd0, 4'd7, 4'd5, 1, 1, 0, 0));
        conf_pulse();
        check_sb();
        push_exp("resume_006", pack(4'd2, 4'd0, 4'd0, 4'd6, 4'd5, 1, 1, 0, 0));
        tick(TPS);
        check_sb();
        mw.porta = 1'b1;
        push_exp("second_pause", pack(4'd3, 4'd0, 4'd0, 4'd6, 4'd5, 1, 0, 0, 0));
        tick(3);
        check_sb();
        mw.t = 12'h000;
        push_exp("pause_cancel", pack(4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 1, 0, 0, 0));
        conf_pulse();
        check_sb();
        mw.porta = 1'b0;
        tick(3);

        // 5: invalid or zero times are ignored in idle
        vecs[0] = '{t: 12'h07A, r: 4'd3,  porta: 1'b0};
        vecs[1] = '{t: 12'h060, r: 4'd9,  porta: 1'b0};
        vecs[2] = '{t: 12'h000, r: 4'd5,  porta: 1'b0};
        vecs[3] = '{t: 12'hA05, r: 4'd7,  porta: 1'b0};
        vecs[4] = '{t: 12'h0C3, r: 4'd12, porta: 1'b1};
        vecs[5] = '{t: 12'h000, r: 4'd0,  porta: 1'b1};
        for (int i = 0; i < 6; i++) begin
            mw.t     = vecs[i].t;
            mw.r     = vecs[i].r;
            mw.porta = vecs[i].porta;
            push_exp($sformatf("idle_ignore_%0d", i),
                     pack(4'd0, vecs[i].t[11:8], vecs[i].t[7:4], vecs[i].t[3:0],
                          vecs[i].r, vecs[i].porta, 0, 0, 0));
            conf_pulse();
            tick(2);
            check_sb();
        end
        mw.porta = 1'b0;
        tick(3);

        // door opening on the final tick: DONE wins, then door ends the beep
        mw.t = 12'h001; mw.r = 4'd3;
        tick(2);
        conf_pulse();
        tick(1);
        mw.porta = 1'b1;
        push_exp("final_tick_door_done", pack(4'd4, 4'd0, 4'd0, 4'd0, 4'd3, 1, 0, 0, 1));
        tick(3);
        check_sb();
        push_exp("done_door_idle", pack(4'd0, 4'd0, 4'd0, 4'd1, 4'd3, 1, 0, 0, 0));
        tick(1);
        check_sb();
        mw.porta = 1'b0;
        tick(3);

        // 6: asynchronous reset mid-cook at 0:05 with continuous power
        mw.t = 12'h012; mw.r = 4'd10;
        tick(2);
        push_exp("cont_start", pack(4'd2, 4'd0, 4'd1, 4'd2, 4'hA, 1, 1, 1, 0));
        conf_pulse();
        check_sb();
        push_exp("cont_005", pack(4'd2, 4'd0, 4'd0, 4'd5, 4'hA, 1, 1, 1, 0));
        tick(7 * TPS);
        check_sb();
        #2 rst_n = 1'b0;
        push_exp("async_reset", 24'h0);
        #1;
        check_sb();
        tick(2);
        #2 rst_n = 1'b1;
        push_exp("after_reset_idle", pack(4'd0, 4'd0, 4'd1, 4'd2, 4'hA, 0, 0, 0, 0));
        tick(2);
        check_sb();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
